// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter: the grant FSM states,
// the master identifiers used for round-robin history, and the watchdog width.
package wb_bus_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_INST, ARB_DATA} arb_state_t;
    typedef enum logic {ARB_M_INST, ARB_M_DATA} arb_master_t;

    localparam int WDOG_W = 16;

    // Bus state that grants the given master.
    function automatic arb_state_t grant_state(arb_master_t m);
        return (m == ARB_M_INST) ? ARB_INST : ARB_DATA;
    endfunction

    // Round-robin pick on a tie: whoever did not release last.
    function automatic arb_master_t rr_pick(arb_master_t last);
        return (last == ARB_M_INST) ? ARB_M_DATA : ARB_M_INST;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone B4 classic port bundle. The master modport is the side that
// issues requests; the slave modport is the side that answers them.
interface wb_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat_r;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_bus_arbiter_watchdog.sv
// Per-transfer watchdog: counts consecutive strobed cycles without a slave
// answer and pulses 'expired' for one cycle when the count hits TIMEOUT.
module bus_watchdog
    import wb_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic done,
    input  logic clear,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] count_q;
    logic              at_limit;

    assign at_limit = (count_q == LIMIT);
    // A real slave answer on the same cycle beats the timeout.
    assign expired  = strobe && !done && !clear && at_limit;

    // Wait counter; restarts on any answer, grant change, idle bus or expiry.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            count_q <= '0;
        end else if (clear || done || !strobe || at_limit) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter. Round-robin on ties,
// bus locked to a master for the whole of its cyc, registered grant,
// combinational response path, watchdog-generated err on stalled accesses.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_bus_arbiter_if.slave        i_bus,
    wb_bus_arbiter_if.slave        d_bus,
    wb_bus_arbiter_if.master       m_bus
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t  state_q, state_d;
    arb_master_t last_q, last_d;

    logic              cyc_mux, stb_mux, we_mux;
    logic [ADDR_W-1:0] adr_mux;
    logic [DATA_W-1:0] dat_mux;
    logic [SEL_W-1:0]  sel_mux;

    logic grant_inst, grant_data;
    logic wdog_clear, wdog_expired;

    // Grant state and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            last_q  <= ARB_M_DATA;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next grant: arbitrate from idle, hold while locked, hand over on release.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_bus.cyc && d_bus.cyc) begin
                    state_d = grant_state(rr_pick(last_q));
                end else if (i_bus.cyc) begin
                    state_d = ARB_INST;
                end else if (d_bus.cyc) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_INST: begin
                if (!i_bus.cyc) begin
                    last_d  = ARB_M_INST;
                    state_d = d_bus.cyc ? ARB_DATA : ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (!d_bus.cyc) begin
                    last_d  = ARB_M_DATA;
                    state_d = i_bus.cyc ? ARB_INST : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_inst = (state_q == ARB_INST);
    assign grant_data = (state_q == ARB_DATA);

    // Shared request mux: granted master's signals, all zero when idle.
    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        if (grant_inst) begin
            cyc_mux = i_bus.cyc;
            stb_mux = i_bus.stb;
            we_mux  = i_bus.we;
            adr_mux = i_bus.adr;
            dat_mux = i_bus.dat_w;
            sel_mux = i_bus.sel;
        end else if (grant_data) begin
            cyc_mux = d_bus.cyc;
            stb_mux = d_bus.stb;
            we_mux  = d_bus.we;
            adr_mux = d_bus.adr;
            dat_mux = d_bus.dat_w;
            sel_mux = d_bus.sel;
        end
    end

    assign m_bus.cyc   = cyc_mux;
    assign m_bus.stb   = stb_mux;
    assign m_bus.we    = we_mux;
    assign m_bus.adr   = adr_mux;
    assign m_bus.dat_w = dat_mux;
    assign m_bus.sel   = sel_mux;

    // Read data fans out to both masters; handshakes reach only the granted one.
    assign i_bus.dat_r = m_bus.dat_r;
    assign d_bus.dat_r = m_bus.dat_r;
    assign i_bus.ack   = grant_inst & m_bus.ack;
    assign d_bus.ack   = grant_data & m_bus.ack;
    assign i_bus.err   = grant_inst & (m_bus.err | wdog_expired);
    assign d_bus.err   = grant_data & (m_bus.err | wdog_expired);

    // A grant change starts the new owner's wait count from zero.
    assign wdog_clear = (state_d != state_q);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .strobe  (stb_mux),
        .done    (m_bus.ack | m_bus.err),
        .clear   (wdog_clear),
        .expired (wdog_expired)
    );

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with a response scoreboard.
module tb_wb_bus_arbiter;
    import wb_bus_arbiter_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        string       tag;
        arb_master_t who;
        logic [31:0] dat;
        logic        is_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    wb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
    wb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
    wb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

    wb_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_bus (i_bus),
        .d_bus (d_bus),
        .m_bus (m_bus)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_i(logic cyc, logic stb, logic we, logic [31:0] adr, logic [31:0] dat);
        i_bus.cyc = cyc; i_bus.stb = stb; i_bus.we = we;
        i_bus.adr = adr; i_bus.dat_w = dat; i_bus.sel = 4'hF;
    endtask

    task automatic drive_d(logic cyc, logic stb, logic we, logic [31:0] adr, logic [31:0] dat);
        d_bus.cyc = cyc; d_bus.stb = stb; d_bus.we = we;
        d_bus.adr = adr; d_bus.dat_w = dat; d_bus.sel = 4'hF;
    endtask

    task automatic slave(logic ack, logic err, logic [31:0] dat);
        m_bus.ack = ack; m_bus.err = err; m_bus.dat_r = dat;
    endtask

    task automatic expect_resp(string tag, arb_master_t who, logic [31:0] dat, logic is_err);
        exp_t e;
        e.tag = tag; e.who = who; e.dat = dat; e.is_err = is_err;
        sb.push_back(e);
    endtask

    // Any master-side response pops the oldest expectation and is compared to it.
    task automatic observe();
        logic [3:0]  rv;
        logic [3:0]  ev;
        logic [31:0] dv;
        exp_t        e;
        rv = {i_bus.ack, i_bus.err, d_bus.ack, d_bus.err};
        if (rv != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(rv), 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.who == ARB_M_INST) ev = e.is_err ? 4'b0100 : 4'b1000;
                else                     ev = e.is_err ? 4'b0001 : 4'b0010;
                dv = (e.who == ARB_M_INST) ? i_bus.dat_r : d_bus.dat_r;
                check({e.tag, "_resp"}, 64'(rv), 64'(ev));
                check({e.tag, "_dat"}, 64'(dv), 64'(e.dat));
            end
        end
    endtask

    task automatic sample();
        #1;
        observe();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        drive_i(0, 0, 0, 0, 0);
        drive_d(0, 0, 0, 0, 0);
        slave(0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        drive_i(0, 0, 0, 0, 0);
        drive_d(0, 0, 0, 0, 0);
        slave(0, 0, 0);

        // Reset state: idle bus, gated handshakes, read data follows slave.
        reset_dut();
        slave(1, 1, 32'h1234_5678);
        #1;
        check("rst_m_cyc", 64'(m_bus.cyc), 64'd0);
        check("rst_m_stb", 64'(m_bus.stb), 64'd0);
        check("rst_m_adr", 64'(m_bus.adr), 64'd0);
        check("rst_resp", 64'({i_bus.ack, i_bus.err, d_bus.ack, d_bus.err}), 64'd0);
        check("rst_i_dat", 64'(i_bus.dat_r), 64'h1234_5678);
        check("rst_d_dat", 64'(d_bus.dat_r), 64'h1234_5678);
        slave(0, 0, 0);

        // Single instruction read, slave answers on the second bus cycle.
        @(negedge clk); drive_i(1, 1, 0, 32'h100, 0); sample();
        check("t1_no_grant_yet", 64'(m_bus.cyc), 64'd0);
        @(negedge clk); sample();
        check("t1_m_cyc", 64'(m_bus.cyc), 64'd1);
        check("t1_m_adr", 64'(m_bus.adr), 64'h100);
        check("t1_m_we", 64'(m_bus.we), 64'd0);
        @(negedge clk); slave(1, 0, 32'hDEAD_BEEF);
        expect_resp("t1_read", ARB_M_INST, 32'hDEAD_BEEF, 0); sample();
        check("t1_d_ack", 64'(d_bus.ack), 64'd0);
        @(negedge clk); slave(0, 0, 0); drive_i(0, 0, 0, 32'h100, 0); sample();
        @(negedge clk); sample();
        check("t1_idle_cyc", 64'(m_bus.cyc), 64'd0);
        check("t1_idle_adr", 64'(m_bus.adr), 64'd0);
        check("t1_drain", 64'(sb.size()), 64'd0);

        // Tie after reset goes to instruction; data follows with no idle gap.
        reset_dut();
        @(negedge clk); drive_i(1, 1, 0, 32'h200, 0); drive_d(1, 1, 1, 32'h300, 32'hAAAA_5555); sample();
        @(negedge clk); slave(1, 0, 32'h1111_1111);
        expect_resp("t2_inst", ARB_M_INST, 32'h1111_1111, 0); sample();
        check("t2_tie_adr", 64'(m_bus.adr), 64'h200);
        @(negedge clk); slave(0, 0, 0); drive_i(0, 0, 0, 32'h200, 0); sample();
        @(negedge clk); drive_i(1, 1, 0, 32'h204, 0); slave(1, 0, 32'h2222_2222);
        expect_resp("t2_data", ARB_M_DATA, 32'h2222_2222, 0); sample();
        check("t2_handover_adr", 64'(m_bus.adr), 64'h300);
        check("t2_handover_we", 64'(m_bus.we), 64'd1);
        check("t2_handover_dat", 64'(m_bus.dat_w), 64'hAAAA_5555);
        @(negedge clk); slave(0, 0, 0); drive_d(0, 0, 0, 32'h300, 0); sample();
        @(negedge clk); slave(1, 0, 32'h3333_3333);
        expect_resp("t2_inst2", ARB_M_INST, 32'h3333_3333, 0); sample();
        check("t2_inst2_adr", 64'(m_bus.adr), 64'h204);
        @(negedge clk); slave(0, 0, 0); drive_i(0, 0, 0, 0, 0); sample();
        @(negedge clk); sample();
        check("t2_drain", 64'(sb.size()), 64'd0);

        // Data holds the lock over three writes while instruction waits.
        @(negedge clk); drive_d(1, 1, 1, 32'h10, 32'hA0); drive_i(1, 1, 0, 32'h400, 0); sample();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_d(1, 1, 1, 32'h10 + 32'(4 * k), 32'hA0 + 32'(k));
            slave(1, 0, 32'(k));
            expect_resp("t3_wr", ARB_M_DATA, 32'(k), 0); sample();
            check("t3_wr_adr", 64'(m_bus.adr), 64'h10 + 64'(4 * k));
            check("t3_wr_dat", 64'(m_bus.dat_w), 64'hA0 + 64'(k));
        end
        @(negedge clk); slave(0, 0, 0); drive_d(0, 0, 0, 32'h18, 0); sample();
        check("t3_release_cyc", 64'(m_bus.cyc), 64'd0);
        @(negedge clk); slave(1, 0, 32'h4444_4444);
        expect_resp("t3_inst", ARB_M_INST, 32'h4444_4444, 0); sample();
        check("t3_inst_adr", 64'(m_bus.adr), 64'h400);
        @(negedge clk); slave(0, 0, 0); drive_i(0, 0, 0, 0, 0); sample();
        @(negedge clk); sample();
        check("t3_drain", 64'(sb.size()), 64'd0);

        // Stalled data read: err exactly TIMEOUT cycles after the first strobe.
        @(negedge clk); drive_d(1, 1, 0, 32'h500, 0); sample();
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == TIMEOUT) expect_resp("t4_timeout", ARB_M_DATA, 32'h0, 1);
            sample();
            check("t4_d_err", 64'(d_bus.err), 64'(k == TIMEOUT));
            check("t4_d_ack", 64'(d_bus.ack), 64'd0);
        end
        @(negedge clk); drive_d(0, 0, 0, 32'h500, 0); sample();
        check("t4_err_pulse", 64'(d_bus.err), 64'd0);
        // Same stall, but the ack lands on the timeout cycle: ack wins.
        @(negedge clk); drive_d(1, 1, 0, 32'h504, 0); sample();
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == TIMEOUT) begin
                slave(1, 0, 32'h5A5A_5A5A);
                expect_resp("t4_late_ack", ARB_M_DATA, 32'h5A5A_5A5A, 0);
            end
            sample();
            check("t4b_d_err", 64'(d_bus.err), 64'd0);
        end
        @(negedge clk); slave(0, 0, 0); drive_d(0, 0, 0, 0, 0); sample();
        @(negedge clk); sample();
        check("t4_drain", 64'(sb.size()), 64'd0);

        // Reset during a granted data write abandons it silently.
        @(negedge clk); drive_d(1, 1, 1, 32'h600, 32'hCAFE); sample();
        @(negedge clk); rst = 1'b0; sample();
        check("t5_granted", 64'(m_bus.cyc), 64'd1);
        @(negedge clk); slave(1, 0, 32'h0); sample();
        check("t5_rst_cyc", 64'(m_bus.cyc), 64'd0);
        check("t5_rst_stb", 64'(m_bus.stb), 64'd0);
        check("t5_rst_resp", 64'({i_bus.ack, i_bus.err, d_bus.ack, d_bus.err}), 64'd0);
        @(negedge clk); rst = 1'b1; slave(0, 0, 0);
        drive_d(1, 1, 0, 32'h604, 0); drive_i(1, 1, 0, 32'h800, 0); sample();
        check("t5_idle_after_rst", 64'(m_bus.cyc), 64'd0);
        @(negedge clk); slave(1, 0, 32'h6666_6666);
        expect_resp("t5_rearb_inst", ARB_M_INST, 32'h6666_6666, 0); sample();
        check("t5_rearb_adr", 64'(m_bus.adr), 64'h800);
        @(negedge clk); slave(0, 0, 0); drive_i(0, 0, 0, 0, 0); sample();
        @(negedge clk); slave(1, 0, 32'h7777_7777);
        expect_resp("t5_rearb_data", ARB_M_DATA, 32'h7777_7777, 0); sample();
        check("t5_data_adr", 64'(m_bus.adr), 64'h604);
        @(negedge clk); slave(0, 0, 0); drive_d(0, 0, 0, 0, 0); sample();
        @(negedge clk); sample();
        check("t5_drain", 64'(sb.size()), 64'd0);

        // Slave err to instruction passes through and restarts the watchdog.
        @(negedge clk); drive_i(1, 1, 0, 32'h700, 0); sample();
        @(negedge clk); slave(0, 1, 32'h0);
        expect_resp("t6_slave_err", ARB_M_INST, 32'h0, 1); sample();
        check("t6_i_err", 64'(i_bus.err), 64'd1);
        check("t6_d_err", 64'(d_bus.err), 64'd0);
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 0) begin
                slave(0, 0, 32'h0);
                drive_i(1, 1, 0, 32'h704, 0);
            end
            if (k == TIMEOUT) expect_resp("t6_timeout", ARB_M_INST, 32'h0, 1);
            sample();
            check("t6_wdog_restart", 64'(i_bus.err), 64'(k == TIMEOUT));
        end
        @(negedge clk); drive_i(0, 0, 0, 0, 0); sample();
        @(negedge clk); sample();
        check("t6_drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master to one-slave Wishbone B4 (classic) arbiter that shares a single memory port between the core's instruction-fetch master and data (load/store) master. Sits between `core` and the unified memory/interconnect. Provides round-robin arbitration with bus locking for the duration of a master's `cyc`. A per-transfer watchdog terminates a stalled slave access with `err`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `SEL_W = DATA_W/8`
- `TIMEOUT`, 255, cycles a strobed access may wait for `ack` before `err` (range 2..65535)

Ports:
- `clk` in 1, system clock
- `rst` in 1, reset, synchronous, active-low
- `i_cyc_i`, `i_stb_i`, `i_we_i` in 1 each; `i_adr_i` in ADDR_W; `i_dat_i` in DATA_W; `i_sel_i` in SEL_W: instruction master request
- `i_dat_o` out DATA_W; `i_ack_o`, `i_err_o` out 1: instruction master response
- `d_cyc_i`, `d_stb_i`, `d_we_i`, `d_adr_i`, `d_dat_i`, `d_sel_i`: data master request, same widths
- `d_dat_o`, `d_ack_o`, `d_err_o`: data master response
- `m_cyc_o`, `m_stb_o`, `m_we_o` out 1; `m_adr_o` out ADDR_W; `m_dat_o` out DATA_W; `m_sel_o` out SEL_W: shared slave request
- `m_dat_i` in DATA_W; `m_ack_i`, `m_err_i` in 1: shared slave response

## Operation
- States: `ARB_IDLE`, `ARB_INST`, `ARB_DATA`. Reset -> `ARB_IDLE`, `last` = `ARB_DATA`.
- `ARB_IDLE`: only `i_cyc_i` -> `ARB_INST`; only `d_cyc_i` -> `ARB_DATA`; both -> master not equal to `last`; neither -> stay.
- `ARB_INST`/`ARB_DATA`: held while the granted master's `cyc` is high (lock). On the cycle the granted `cyc` is low: go directly to other master's state if its `cyc` is high, else `ARB_IDLE`; `last` updated to the releasing master.
- Shared request outputs: combinational mux of the granted master's signals; all-zero in `ARB_IDLE`.
- Responses: `m_dat_i` routed to both `*_dat_o`; `m_ack_i`/`m_err_i` gated to the granted master only; non-granted `ack`/`err` always 0.
- Watchdog: 16-bit counter, increments each cycle `m_stb_o & !m_ack_i & !m_err_i`; cleared on `ack`, `err`, grant change, or `!m_stb_o`. When it reaches `TIMEOUT`, granted master gets `*_err_o`=1 for one cycle (ack suppressed that cycle), counter cleared. Slave is not notified other than by the master dropping `cyc`.
- Slave `m_err_i` passed through unchanged as `*_err_o`.
- Simultaneous `m_ack_i` and timeout: `ack` wins, no `err`.

## Timing
- Grant latency: request in `ARB_IDLE` at cycle N -> `m_cyc_o` at N+1 (registered grant). Handover: release at N -> other master on bus at N+1; no idle cycle inserted.
- Response path (`m_ack_i`->`*_ack_o`, `m_dat_i`->`*_dat_o`) purely combinational, zero latency.
- Reset values: state `ARB_IDLE`, all `m_*_o` = 0, all `*_ack_o`/`*_err_o` = 0, `*_dat_o` follows `m_dat_i`, counter 0.
- `rst` low mid-transfer: next edge state `ARB_IDLE`, `m_cyc_o`=0, counter 0; in-flight transfer abandoned, no ack/err to either master.
- Timeout `err` asserted the cycle counter == `TIMEOUT`, i.e. `TIMEOUT` cycles after first unacknowledged strobe cycle.

## Structure
- `global_pkg` additions: `typedef enum logic [1:0] {ARB_IDLE, ARB_INST, ARB_DATA} arb_state_t;` and `typedef enum logic {ARB_M_INST, ARB_M_DATA} arb_master_t;` (for `last`).
- One sub-module: `bus_watchdog` (counter, `TIMEOUT` parameter, inputs `strobe`, `done`, `clear`; output `expired` one-cycle pulse).
- Arbiter FSM and muxes in `wb_bus_arbiter` top.

## Test plan
- Only instruction master reads 0x0000_0100, slave acks after 2 cycles with 0xDEAD_BEEF -> `m_cyc_o` rises 1 cycle after `i_cyc_i`, `i_ack_o`=1 with `i_dat_o`=0xDEAD_BEEF, `d_ack_o` stays 0.
- Both `cyc` asserted same cycle after reset -> instruction granted first; upon `i_cyc_i` drop, data granted next cycle with no idle gap; next tie goes to instruction again only after data releases.
- Data master holds `cyc` over 3 back-to-back writes (0x10,0x14,0x18) while instruction requests -> all three complete on bus before instruction is granted.
- `TIMEOUT`=4, slave never acks data read -> `d_err_o` pulses exactly 4 cycles after first `m_stb_o` cycle, `d_ack_o` never 1; `m_ack_i` arriving on that same cycle instead yields ack, no err.
- `rst` driven low during granted data write -> next cycle `m_cyc_o`=0, state idle, no ack/err; after release, fresh arbitration works.
- Slave returns `m_err_i` to instruction master -> `i_err_o`=1 same cycle, `d_err_o`=0, watchdog cleared.
